alu_req_master: RTL and testbench

ALU_REQ_MASTER -- requirements
Module: alu_req_master

---
 rtl/alu_req_master.sv | 131 +++++++++++++
 tb/tb_alu_req_master.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_master.sv
// alu_req_master: queues 4-bit ALU commands, drives them onto an external ALU,
// waits SETTLE cycles, then captures result and integrity flag as a response.
module alu_req_master #(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [3:0] cmd_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [3:0] alu_out1,
  input  logic [3:0] alu_out2,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic       rsp_err,
  output logic [7:0] err_count,
  output logic       busy
);

  localparam int unsigned DW = 4;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = 4;

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  logic [3*DW-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic [TW-1:0]   settle_cnt;
  state_t          state;
  state_t          state_next;
  logic            push_c;
  logic            pop_c;
  logic            cap_c;
  logic            hs_c;
  logic            fifo_empty_c;

  assign push_c       = cmd_valid && cmd_ready;
  assign hs_c         = rsp_valid && rsp_ready;
  assign fifo_empty_c = (count == '0);
  assign count_next   = count + CW'(push_c) - CW'(pop_c);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty_c) state_next = DRIVE;
      DRIVE:   if (settle_cnt == '0) state_next = RESP;
      RESP:    if (hs_c) state_next = fifo_empty_c ? IDLE : DRIVE;
      default: state_next = IDLE;
    endcase
  end

  // FSM control strobes: FIFO pop and result capture
  always_comb begin
    pop_c = 1'b0;
    cap_c = 1'b0;
    case (state)
      IDLE:    pop_c = !fifo_empty_c;
      DRIVE:   cap_c = (settle_cnt == '0);
      RESP:    pop_c = hs_c && !fifo_empty_c;
      default: ;
    endcase
  end

  // FIFO storage; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (!rst && push_c) mem[wr_ptr] <= {cmd_a, cmd_b, cmd_op};
  end

  // FIFO pointers, occupancy and flags derived from next-cycle occupancy/state
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
      count     <= count_next;
      cmd_ready <= (count_next < CW'(DEPTH));
      busy      <= (state_next != IDLE) || (count_next != '0);
      rsp_valid <= (state_next == RESP);
    end
  end

  // ALU drive, settle counter, response capture and error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      settle_cnt <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      err_count  <= '0;
    end else begin
      if (pop_c) begin
        {alu_a, alu_b, alu_op} <= mem[rd_ptr];
        settle_cnt             <= TW'(SETTLE - 1);
      end else if (state == DRIVE && settle_cnt != '0) begin
        settle_cnt <= settle_cnt - TW'(1);
      end
      if (cap_c) begin
        rsp_data <= alu_out1;
        rsp_err  <= (alu_out2 != ~alu_out1);
      end
      if (hs_c && rsp_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_req_master.sv
// Testbench for alu_req_master: behavioural ALU, scoreboard queue and directed scenarios.
module tb_alu_req_master;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_a, cmd_b, cmd_op;
  logic [3:0] alu_a, alu_b, alu_op, alu_out1, alu_out2;
  logic       rsp_valid, rsp_ready, rsp_err, busy;
  logic [3:0] rsp_data;
  logic [7:0] err_count;

  logic       cmd_valid3, cmd_ready3, rsp_valid3, rsp_err3, busy3;
  logic       rsp_ready3 = 1'b1;
  logic [3:0] cmd_a3, cmd_b3, cmd_op3, alu_a3, alu_b3, alu_op3, out1_3, out2_3, rsp_data3;
  logic [7:0] err_count3;

  logic       alu_fault = 1'b0;
  logic [7:0] cyc = 8'd0;
  bit         mon_en = 1'b0;
  bit         rand_rdy = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_rsp = 0;
  int         model_err = 0;

  typedef struct {logic [3:0] data; logic err;} exp_t;
  exp_t       exp_q[$];
  logic       hold_pend = 1'b0;
  logic [3:0] hold_data;
  logic       hold_err;

  alu_req_master #(.SETTLE(1), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out1(alu_out1), .alu_out2(alu_out2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .err_count(err_count), .busy(busy)
  );

  alu_req_master #(.SETTLE(3), .DEPTH(DEPTH)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_op(cmd_op3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3),
    .alu_out1(out1_3), .alu_out2(out2_3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
    .rsp_err(rsp_err3), .err_count(err_count3), .busy(busy3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 8'd1;

  function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    case (op[1:0])
      2'b11:   return a + b;
      2'b10:   return a - b;
      2'b01:   return a & b;
      default: return a | b;
    endcase
  endfunction

  // Behavioural ALU; fault mode makes out2 a copy of out1
  always_comb begin
    alu_out1 = alu_fn(alu_a, alu_b, alu_op);
    alu_out2 = alu_fault ? alu_out1 : ~alu_out1;
  end

  // Second ALU output ramps every cycle so the sampling cycle is observable
  assign out1_3 = cyc[3:0];
  assign out2_3 = ~cyc[3:0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: record accepted commands, check responses, hold and error count
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) check("err_count", 32'(err_count), 32'(model_err));
    if (rst) begin
      exp_q.delete();
      model_err = 0;
      hold_pend = 1'b0;
    end else begin
      if (mon_en && hold_pend && rsp_valid) begin
        check("hold_data", 32'(rsp_data), 32'(hold_data));
        check("hold_err", 32'(rsp_err), 32'(hold_err));
      end
      if (cmd_valid && cmd_ready) begin
        e.data = alu_fn(cmd_a, cmd_b, cmd_op);
        e.err  = alu_fault;
        exp_q.push_back(e);
      end
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        if (exp_q.size() == 0) check("stale_rsp", 32'(rsp_valid), 32'(0));
        else begin
          e = exp_q.pop_front();
          check("rsp_data", 32'(rsp_data), 32'(e.data));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          if (e.err && model_err < 255) model_err++;
        end
      end
      hold_pend = rsp_valid && !rsp_ready;
      hold_data = rsp_data;
      hold_err  = rsp_err;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    logic acc;
    acc = 1'b0;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
    for (int i = 0; i < 500 && !acc; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      step();
    end
    cmd_valid = 1'b0;
    if (!acc) check("push_timeout", 32'(acc), 32'(1));
  endtask

  task automatic drain();
    for (int i = 0; i < 5000; i++) begin
      if (exp_q.size() == 0 && !busy && !rsp_valid) break;
      step();
    end
    check("drain_empty", 32'(exp_q.size()), 32'(0));
    check("drain_busy", 32'(busy), 32'(0));
  endtask

  initial begin
    int base;
    int c0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0;
    cmd_valid3 = 1'b0; cmd_a3 = '0; cmd_b3 = '0; cmd_op3 = '0;
    step(); step();
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_alu", 32'({alu_a, alu_b, alu_op}), 32'(0));
    check("rst_rsp_data", 32'({rsp_data, rsp_err}), 32'(0));
    check("rst_err_count", 32'(err_count), 32'(0));
    rst = 1'b0;
    mon_en = 1'b1;

    // Latency t+SETTLE+2 with SETTLE=1
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_a = 4'd3; cmd_b = 4'd4; cmd_op = 4'd3;
    step(); cmd_valid = 1'b0;
    check("lat_t1", 32'(rsp_valid), 32'(0));
    step(); check("lat_t2", 32'(rsp_valid), 32'(0));
    step(); check("lat_t3", 32'(rsp_valid), 32'(1));
    check("lat_data", 32'(rsp_data), 32'(7));
    check("lat_err", 32'(rsp_err), 32'(0));
    drain();

    // Opcode set, including subtraction wrap
    push(4'd2, 4'd5, 4'd2);
    push(4'd12, 4'd10, 4'd1);
    push(4'd12, 4'd10, 4'd0);
    drain();

    // SETTLE=3: sample taken on third DRIVE cycle, operands held throughout
    cmd_valid3 = 1'b1; cmd_a3 = 4'd9; cmd_b3 = 4'd6; cmd_op3 = 4'd3;
    step(); cmd_valid3 = 1'b0; c0 = int'(cyc);
    check("s3_t1_valid", 32'(rsp_valid3), 32'(0));
    for (int k = 2; k <= 4; k++) begin
      step();
      check("s3_alu_hold", 32'({alu_a3, alu_b3, alu_op3}), 32'({4'd9, 4'd6, 4'd3}));
      check("s3_valid_low", 32'(rsp_valid3), 32'(0));
    end
    step();
    check("s3_valid", 32'(rsp_valid3), 32'(1));
    check("s3_data", 32'(rsp_data3), 32'(4'(c0 + 3)));
    check("s3_err", 32'(rsp_err3), 32'(0));
    step();
    check("s3_done", 32'(rsp_valid3), 32'(0));

    // Backpressure: DEPTH+1 commands fill FIFO plus in-flight slot
    rsp_ready = 1'b0;
    base = n_rsp;
    for (int i = 0; i < DEPTH + 1; i++) push(4'($urandom), 4'($urandom), 4'($urandom));
    check("full_ready", 32'(cmd_ready), 32'(0));
    cmd_valid = 1'b1; cmd_a = 4'd1; cmd_b = 4'd1; cmd_op = 4'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      check("full_ready_hold", 32'(cmd_ready), 32'(0));
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
    check("full_rsp_count", 32'(n_rsp - base), 32'(DEPTH + 1));

    // Random traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      push(4'($urandom), 4'($urandom), 4'($urandom));
      if ($urandom_range(0, 3) == 0) step();
    end
    rand_rdy = 1'b0;
    rsp_ready = 1'b1;
    drain();

    // Faulty ALU: every response flagged, counter saturates
    alu_fault = 1'b1;
    for (int i = 0; i < 300; i++) push(4'($urandom), 4'($urandom), 4'($urandom));
    drain();
    alu_fault = 1'b0;
    check("err_sat", 32'(err_count), 32'(255));

    // Reset while a response is pending and two commands are queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(4'($urandom), 4'($urandom), 4'($urandom));
    for (int i = 0; i < 20 && !rsp_valid; i++) step();
    check("pre_rst_valid", 32'(rsp_valid), 32'(1));
    rst = 1'b1; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_a = 4'd5; cmd_b = 4'd5; cmd_op = 4'd3;
    step();
    rst = 1'b0; cmd_valid = 1'b0;
    check("mrst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("mrst_cmd_ready", 32'(cmd_ready), 32'(1));
    check("mrst_busy", 32'(busy), 32'(0));
    check("mrst_alu", 32'({alu_a, alu_b, alu_op}), 32'(0));
    check("mrst_err_count", 32'(err_count), 32'(0));
    for (int i = 0; i < 10; i++) step();
    check("post_rst_valid", 32'(rsp_valid), 32'(0));
    check("post_rst_busy", 32'(busy), 32'(0));
    check("post_rst_q", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
